param_register_file: RTL

- Parametrised successor to the processor's 32x32 register file: configurable data width and depth, an optional hardwired zero register, and two configurable debug tap outputs.
- Adds a synchronous reset clear and a per-register pending-write scoreboard so the control unit can detect read-after-write hazards.
- Sits between decode (read ports, issue), writeback (write port) and the board display logic (taps).

---
 rtl/param_register_file_pkg.sv | 18 +
 rtl/param_register_file_if.sv | 34 +++
 rtl/param_register_file_regfile_scoreboard.sv | 54 +++++
 rtl/param_register_file.sv | 87 ++++++++
 4 files changed

// File: rtl/param_register_file_pkg.sv
// Shared constants for the parametrised register file.
// Holds the default geometry (DATA_W_DEF, ADDR_W_DEF) and the register index
// constants that the board display taps and decode logic refer to.
// Optional build macro honoured by the slice: PARAM_REGFILE_BYPASS_EN.
package param_register_file_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_T0   = 8;
  localparam int unsigned REG_T1   = 9;
  localparam int unsigned REG_T2   = 10;
  localparam int unsigned REG_T3   = 11;
  localparam int unsigned REG_T4   = 12;
  localparam int unsigned REG_T5   = 13;

endpackage

// File: rtl/param_register_file_if.sv
// Bus bundle between decode/writeback/display and the register file.
// master: drives write, read-address and issue signals; receives read data,
//         busy flags and taps.
// slave : the register file itself.
interface param_register_file_if
  import param_register_file_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic              busy1;
  logic              busy2;
  logic [DATA_W-1:0] tap1;
  logic [DATA_W-1:0] tap2;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, issue_en, issue_addr,
    input  rd_data1, rd_data2, busy1, busy2, tap1, tap2
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, issue_en, issue_addr,
    output rd_data1, rd_data2, busy1, busy2, tap1, tap2
  );
endinterface

// File: rtl/param_register_file_regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write vector.
// Ports: clk, rst (sync, active high); issue_en/issue_addr set a pending bit;
//        wr_en/wr_addr clear it; rd_addr1/rd_addr2 look up busy1/busy2.
// Macro PARAM_REGFILE_BYPASS_EN: a same-cycle write to the looked-up address
// hides its pending bit unless the same cycle also issues to that address.
module regfile_scoreboard #(
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              busy1,
  output logic              busy2
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;

  // Clear first, then set: an issue colliding with a write leaves the bit set
  // because the newly issued instruction is the live producer.
  always_comb begin
    pending_d = pending_q;
    if (wr_en)    pending_d[wr_addr]    = 1'b0;
    if (issue_en) pending_d[issue_addr] = 1'b1;
    if (ZERO_REG) pending_d[0]          = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  function automatic logic lookup(input logic [ADDR_W-1:0] a);
    logic b;
    b = pending_q[a];
`ifdef PARAM_REGFILE_BYPASS_EN
    if (wr_en && (wr_addr == a) && !(ZERO_REG && (a == '0)))
      b = issue_en && (issue_addr == a);
`endif
    return b;
  endfunction

  always_comb begin
    busy1 = lookup(rd_addr1);
    busy2 = lookup(rd_addr2);
  end
endmodule

// File: rtl/param_register_file.sv
// param_register_file: parametrised register file with pending-write
// scoreboard and two debug taps.
// Ports: clk, rst (sync, active high); bus (param_register_file_if.slave)
//        carrying write port, two combinational read ports, issue port,
//        busy flags and tap1/tap2 (contents of TAP1_IDX/TAP2_IDX).
// Macro PARAM_REGFILE_BYPASS_EN: same-cycle write data forwarded to reads.
module param_register_file
  import param_register_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned TAP1_IDX = REG_T4,
  parameter int unsigned TAP2_IDX = REG_T3
) (
  input  logic                 clk,
  input  logic                 rst,
  param_register_file_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  if (TAP1_IDX >= DEPTH) begin : g_tap1_range
    $error("TAP1_IDX out of range for ADDR_W");
  end
  if (TAP2_IDX >= DEPTH) begin : g_tap2_range
    $error("TAP2_IDX out of range for ADDR_W");
  end

  localparam logic [ADDR_W-1:0] TAP1_A = ADDR_W'(TAP1_IDX);
  localparam logic [ADDR_W-1:0] TAP2_A = ADDR_W'(TAP2_IDX);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  function automatic logic [DATA_W-1:0] stored(input logic [ADDR_W-1:0] a);
    return is_zero(a) ? '0 : regs_q[a];
  endfunction

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = stored(a);
`ifdef PARAM_REGFILE_BYPASS_EN
    if (bus.wr_en && (bus.wr_addr == a) && !is_zero(a)) v = bus.wr_data;
`endif
    return v;
  endfunction

  always_comb begin
    regs_d = regs_q;
    if (bus.wr_en && !is_zero(bus.wr_addr)) regs_d[bus.wr_addr] = bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    bus.rd_data1 = read_port(bus.rd_addr1);
    bus.rd_data2 = read_port(bus.rd_addr2);
    bus.tap1     = stored(TAP1_A);
    bus.tap2     = stored(TAP2_A);
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issue_en   (bus.issue_en),
    .issue_addr (bus.issue_addr),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .rd_addr1   (bus.rd_addr1),
    .rd_addr2   (bus.rd_addr2),
    .busy1      (bus.busy1),
    .busy2      (bus.busy2)
  );
endmodule
